ex_muldiv: RTL

Execute-stage multiply/divide unit. It takes the operation and operands that the ID/EX pipeline register presents to EX, and produces HI/LO write-back data plus a stall request to the pipeline controller. MULT/MULTU finish in one cycle, MADD/MADDU/MSUB/MSUBU in two, and DIV/DIVU use an iterative 32-step divider. It sits inside EX, in parallel with the ALU result path, and its HI/LO outputs feed the EX/MEM register.

---
 rtl/ex_muldiv_pkg.sv | 33 +++
 rtl/ex_muldiv_if.sv | 26 ++
 rtl/ex_muldiv_div_iter.sv | 119 +++++++++++
 rtl/ex_muldiv.sv | 116 +++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared op codes, divider state encoding and helpers for the EX-stage multiply/divide unit.
// The iterative divider is only built when MIPS_DIV_EN is defined.
package ex_muldiv_pkg;

  localparam int REG_BUS    = 32;
  localparam int ALU_OP_BUS = 8;

  localparam logic [ALU_OP_BUS-1:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [ALU_OP_BUS-1:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [ALU_OP_BUS-1:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [ALU_OP_BUS-1:0] EXE_DIVU_OP  = 8'b00011011;
  localparam logic [ALU_OP_BUS-1:0] EXE_MADD_OP  = 8'b10100110;
  localparam logic [ALU_OP_BUS-1:0] EXE_MADDU_OP = 8'b10101000;
  localparam logic [ALU_OP_BUS-1:0] EXE_MSUB_OP  = 8'b10101010;
  localparam logic [ALU_OP_BUS-1:0] EXE_MSUBU_OP = 8'b10101011;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [REG_BUS-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } div_state_t;

  function automatic logic [REG_BUS-1:0] neg_if(input logic [REG_BUS-1:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage operand/result bundle between the ID/EX register side and ex_muldiv.
interface ex_muldiv_if;
  import ex_muldiv_pkg::*;

  logic [ALU_OP_BUS-1:0] aluop_i;
  logic [REG_BUS-1:0]    reg1_i;
  logic [REG_BUS-1:0]    reg2_i;
  logic [REG_BUS-1:0]    hi_i;
  logic [REG_BUS-1:0]    lo_i;
  logic                  annul_i;
  logic [REG_BUS-1:0]    hi_o;
  logic [REG_BUS-1:0]    lo_o;
  logic                  whilo_o;
  logic                  stallreq_o;

  modport master (
    output aluop_i, reg1_i, reg2_i, hi_i, lo_i, annul_i,
    input  hi_o, lo_o, whilo_o, stallreq_o
  );

  modport slave (
    input  aluop_i, reg1_i, reg2_i, hi_i, lo_i, annul_i,
    output hi_o, lo_o, whilo_o, stallreq_o
  );

endinterface

// File: rtl/ex_muldiv_div_iter.sv
// Restoring 32-step divider: IDLE -> (ZERO | 32x ON) -> END, one quotient bit per cycle.
// result = {remainder, quotient}, valid while ready=1.
module div_iter
  import ex_muldiv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [REG_BUS-1:0] dividend,
  input  logic [REG_BUS-1:0] divisor,
  output logic               ready,
  output logic [63:0]        result
);

  div_state_t         state_reg, state_next;
  logic [5:0]         cnt_reg, cnt_next;
  logic [REG_BUS-1:0] quo_reg, quo_next;
  logic [REG_BUS-1:0] rem_reg, rem_next;
  logic [REG_BUS-1:0] dsor_reg, dsor_next;
  logic               neg_quo_reg, neg_quo_next;
  logic               neg_rem_reg, neg_rem_next;
  logic [63:0]        result_reg, result_next;

  logic [32:0]        shifted;
  logic               ge;
  logic [REG_BUS-1:0] diff;
  logic [REG_BUS-1:0] quo_step;
  logic [REG_BUS-1:0] rem_step;

  // The difference only matters when shifted >= divisor, so it always fits in 32 bits.
  always_comb begin
    shifted  = {rem_reg, quo_reg[31]};
    ge       = (shifted >= {1'b0, dsor_reg});
    diff     = shifted[31:0] - dsor_reg;
    quo_step = {quo_reg[30:0], ge};
    rem_step = ge ? diff : shifted[31:0];
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    quo_next     = quo_reg;
    rem_next     = rem_reg;
    dsor_next    = dsor_reg;
    neg_quo_next = neg_quo_reg;
    neg_rem_next = neg_rem_reg;
    result_next  = result_reg;
    ready        = 1'b0;
    if (annul) begin
      state_next = DIV_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          if (start) begin
            if (divisor == ZERO_WORD) begin
              state_next = DIV_ZERO;
            end else begin
              quo_next     = neg_if(dividend, signed_div & dividend[31]);
              dsor_next    = neg_if(divisor, signed_div & divisor[31]);
              rem_next     = ZERO_WORD;
              cnt_next     = '0;
              neg_quo_next = signed_div & (dividend[31] ^ divisor[31]);
              neg_rem_next = signed_div & dividend[31];
              state_next   = DIV_ON;
            end
          end
        end
        DIV_ZERO: begin
          result_next = '0;
          state_next  = DIV_END;
        end
        DIV_ON: begin
          quo_next = quo_step;
          rem_next = rem_step;
          cnt_next = cnt_reg + 6'd1;
          if (cnt_reg == 6'd31) begin
            // Remainder follows the dividend's sign; quotient is negative when signs differ.
            result_next = {neg_if(rem_step, neg_rem_reg), neg_if(quo_step, neg_quo_reg)};
            cnt_next    = '0;
            state_next  = DIV_END;
          end
        end
        DIV_END: begin
          ready      = 1'b1;
          state_next = DIV_IDLE;
        end
        default: state_next = DIV_IDLE;
      endcase
    end
  end

  assign result = result_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= DIV_IDLE;
      cnt_reg     <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      dsor_reg    <= '0;
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      quo_reg     <= quo_next;
      rem_reg     <= rem_next;
      dsor_reg    <= dsor_next;
      neg_quo_reg <= neg_quo_next;
      neg_rem_reg <= neg_rem_next;
      result_reg  <= result_next;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide: single-cycle MULT(U), two-cycle MADD/MSUB(U), iterative DIV(U).
// DIV/DIVU exist only when MIPS_DIV_EN is defined; otherwise they act as NOPs.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);

  logic               cnt_reg, cnt_next;
  logic [63:0]        temp_reg, temp_next;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        hilo_in;
  logic [63:0]        acc;
  logic [REG_BUS-1:0] hi_out, lo_out;
  logic               whilo_out, stall_out;
  logic               is_madd_signed, is_sub;

  // Operands are widened to 64 bits first so the product is exact modulo 2^64.
  assign prod_s  = $signed({{32{bus.reg1_i[31]}}, bus.reg1_i}) *
                   $signed({{32{bus.reg2_i[31]}}, bus.reg2_i});
  assign prod_u  = {32'd0, bus.reg1_i} * {32'd0, bus.reg2_i};
  assign hilo_in = {bus.hi_i, bus.lo_i};

  assign is_madd_signed = (bus.aluop_i == EXE_MADD_OP) || (bus.aluop_i == EXE_MSUB_OP);
  assign is_sub         = (bus.aluop_i == EXE_MSUB_OP) || (bus.aluop_i == EXE_MSUBU_OP);
  assign acc            = is_sub ? (hilo_in - temp_reg) : (hilo_in + temp_reg);

`ifdef MIPS_DIV_EN
  logic        div_start;
  logic        div_signed;
  logic        div_ready;
  logic [63:0] div_result;

  assign div_start  = (bus.aluop_i == EXE_DIV_OP) || (bus.aluop_i == EXE_DIVU_OP);
  assign div_signed = (bus.aluop_i == EXE_DIV_OP);

  div_iter u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start),
    .signed_div (div_signed),
    .annul      (bus.annul_i),
    .dividend   (bus.reg1_i),
    .divisor    (bus.reg2_i),
    .ready      (div_ready),
    .result     (div_result)
  );
`endif

  always_comb begin
    hi_out    = ZERO_WORD;
    lo_out    = ZERO_WORD;
    whilo_out = 1'b0;
    stall_out = NO_STOP;
    cnt_next  = cnt_reg;
    temp_next = temp_reg;
    if (!rst) begin
      if (bus.annul_i) begin
        cnt_next = 1'b0;
      end else begin
        case (bus.aluop_i)
          EXE_MULT_OP: begin
            {hi_out, lo_out} = prod_s;
            whilo_out        = 1'b1;
          end
          EXE_MULTU_OP: begin
            {hi_out, lo_out} = prod_u;
            whilo_out        = 1'b1;
          end
          EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP: begin
            if (!cnt_reg) begin
              temp_next = is_madd_signed ? prod_s : prod_u;
              cnt_next  = 1'b1;
              stall_out = STOP;
            end else begin
              {hi_out, lo_out} = acc;
              whilo_out        = 1'b1;
              cnt_next         = 1'b0;
            end
          end
`ifdef MIPS_DIV_EN
          EXE_DIV_OP, EXE_DIVU_OP: begin
            if (div_ready) begin
              {hi_out, lo_out} = div_result;
              whilo_out        = 1'b1;
            end else begin
              stall_out = STOP;
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.hi_o       = hi_out;
  assign bus.lo_o       = lo_out;
  assign bus.whilo_o    = whilo_out;
  assign bus.stallreq_o = stall_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= 1'b0;
      temp_reg <= '0;
    end else begin
      cnt_reg  <= cnt_next;
      temp_reg <= temp_next;
    end
  end

endmodule
